time_display_driver: RTL and testbench
======================================

// Module: time_display_driver
// PURPOSE
//  Consumer side of the Timer time/alarm outputs: samples hours/minutes/seconds/centiseconds plus ringSound,
//  converts each field to two BCD digits with a sequential double-dabble engine, and drives an 8-digit
//  multiplexed 7-segment display (HH.MM.SS.cc) and a piezo buzzer. Sits between the Timer and board pins.
// PARAMETERS
//  REFRESH_DIV  1_000_000  clocks between input snapshots; must be >= 64
//  SCAN_DIV     100_000    clocks each digit is enabled per scan step
//  TONE_DIV     25_000     clocks per buzzer half-period (tone toggle)
//  BEEP_DIV     25_000_000 clocks per beep gate half-period (tone on / silent)
// PORTS
//  clockSignal          in   1  board clock, all logic rising-edge
//  reset                in   1  asynchronous, active-high
//  timeInHoursDisplay   in   5  binary hours, legal 0..23
//  timeInMinutesDisplay in   6  binary minutes, legal 0..59
//  timeInSeconds        in   6  binary seconds, legal 0..59
//  millisecondsDisplay  in   7  binary centiseconds, legal 0..99
//  ringSound            in   1  alarm request level
//  anodeSelect          out  8  digit enables, active-low, one-hot-zero; bit7 = hours tens
//  segments             out  7  {g,f,e,d,c,b,a}, active-low
//  decimalPoint         out  1  active-low; lit on digits 6, 4, 2 (field separators)
//  buzzerOut            out  1  square-wave tone to piezo
//  rangeError           out  1  high while committed snapshot held any out-of-range field
// BEHAVIOUR
//  Reset: anodeSelect=8'hFF, segments=7'h7F, decimalPoint=1, buzzerOut=0, rangeError=0; FSM IDLE,
//   all counters 0, displayValid=0. While displayValid=0 anodeSelect stays 8'hFF.
//  Refresh: counter wraps at REFRESH_DIV-1; wrap cycle in IDLE snapshots all four fields (one edge,
//   no tearing) and enters CONV. Wrap while not IDLE is ignored (cannot occur given REFRESH_DIV>=64).
//  FSM IDLE -> CONV(field 0..3: hours, minutes, seconds, centiseconds) -> COMMIT -> IDLE.
//   Per field: 1 load cycle + 7 shift cycles (add-3 to any BCD nibble >=5 before each shift) = 8 cycles.
//   COMMIT copies all 8 digits into display register in one cycle, sets displayValid=1.
//   Snapshot-to-display latency = 1 + 32 + 1 = 34 clocks.
//  Range check at snapshot: field > max (23/59/59/99) -> both digits of that field display DASH
//   (segment g only); rangeError reflects the latest committed snapshot.
//  Scan: step counter wraps at SCAN_DIV-1; digit index advances 7,6,...,0,7 on wrap. anodeSelect,
//   segments, decimalPoint registered, change together on the same edge. One blank cycle (8'hFF)
//   at each digit change to avoid ghosting.
//  Leading zeros shown (00.00.00.00 legal display).
//  Buzzer: ringSound through 2-flop synchroniser. While synced high: gate toggles every BEEP_DIV clocks,
//   tone toggles every TONE_DIV clocks, buzzerOut = tone & gate. Gate and tone restart at 0/on on the
//   rising edge of synced ringSound. Synced low -> buzzerOut=0 next cycle; worst case 3 clocks from pin.
//  Reset mid-conversion or mid-beep: everything returns to reset values immediately; no partial commit.
//  Input change during CONV has no effect on the in-flight conversion.
// STRUCTURE
//  Package time_display_pkg: 7-seg encode constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK; field index
//   typedef (F_HOURS, F_MINUTES, F_SECONDS, F_CENTI); field max constants 23/59/59/99; FSM state typedef.
//  Sub-module bin2bcd_seq: 7-bit start/load, 7-cycle double-dabble, done pulse, 8-bit {tens,ones} out.
//  Top holds refresh counter, FSM, snapshot/display registers, scan mux, buzzer generator.
// TESTING (bench params REFRESH_DIV=64, SCAN_DIV=4, TONE_DIV=3, BEEP_DIV=16)
//  1 Reset then inputs 13/45/07/99 -> 34 clocks after first refresh wrap, scan shows 1,3,4,5,0,7,9,9 on
//    digits 7..0, dp low only on digits 6/4/2, rangeError=0.
//  2 Inputs 23/59/59/99 then 0/0/0/0 on next refresh -> 2,3,5,9,5,9,9,9 then all 0 digits; no mixed frame.
//  3 Inputs 24/60/0/100 -> digits 7..4 and 1..0 show SEG_DASH, digits 3..2 show 0,0, rangeError=1;
//    next legal snapshot clears rangeError.
//  4 Change inputs every clock during CONV -> committed digits equal the snapshot-cycle values.
//  5 ringSound high 100 clocks -> buzzerOut toggles every 3 clocks for 16, silent 16, repeats;
//    ringSound low -> buzzerOut=0 within 3 clocks.
//  6 Assert reset mid-CONV and during beep -> same cycle outputs at reset values, anodeSelect=8'hFF
//    until next full commit.

Source files
------------

// File: rtl/time_display_pkg.sv
// Shared constants and types for the time display driver: active-low 7-segment
// patterns, field indices, legal field maxima and the conversion FSM states.
package time_display_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        F_HOURS   = 2'd0,
        F_MINUTES = 2'd1,
        F_SECONDS = 2'd2,
        F_CENTI   = 2'd3
    } field_t;

    localparam logic [6:0] MAX_HOURS   = 7'd23;
    localparam logic [6:0] MAX_MINUTES = 7'd59;
    localparam logic [6:0] MAX_SECONDS = 7'd59;
    localparam logic [6:0] MAX_CENTI   = 7'd99;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] field_max(input field_t field);
        logic [6:0] max_val;
        case (field)
            F_HOURS:   max_val = MAX_HOURS;
            F_MINUTES: max_val = MAX_MINUTES;
            F_SECONDS: max_val = MAX_SECONDS;
            default:   max_val = MAX_CENTI;
        endcase
        return max_val;
    endfunction

endpackage

// File: rtl/time_display_driver_bin2bcd.sv
// Sequential double-dabble: one load cycle, then seven add-3/shift cycles turn a
// 7-bit binary value into {tens, ones}. done pulses for one cycle with bcd valid.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] bcd
);

    // {tens[14:11], ones[10:7], binary[6:0]}
    logic [14:0] work;
    logic [14:0] adjusted;
    logic [2:0]  shift_cnt;

    always_comb begin
        adjusted = work;
        if (work[10:7] >= 4'd5) begin
            adjusted[10:7] = work[10:7] + 4'd3;
        end
        if (work[14:11] >= 4'd5) begin
            adjusted[14:11] = work[14:11] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work      <= '0;
            shift_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                work      <= {8'd0, bin};
                shift_cnt <= '0;
                busy      <= 1'b1;
            end else if (busy) begin
                work      <= {adjusted[13:0], 1'b0};
                shift_cnt <= shift_cnt + 3'd1;
                if (shift_cnt == 3'd6) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bcd = work[14:7];

endmodule

// File: rtl/time_display_driver.sv
// Snapshots Timer fields, converts them to BCD, and drives an 8-digit multiplexed
// 7-segment display (HH.MM.SS.cc) plus a gated square-wave piezo buzzer.
module time_display_driver
    import time_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1_000_000,
    parameter int SCAN_DIV    = 100_000,
    parameter int TONE_DIV    = 25_000,
    parameter int BEEP_DIV    = 25_000_000
) (
    input  logic       clockSignal,
    input  logic       reset,
    input  logic [4:0] timeInHoursDisplay,
    input  logic [5:0] timeInMinutesDisplay,
    input  logic [5:0] timeInSeconds,
    input  logic [6:0] millisecondsDisplay,
    input  logic       ringSound,
    output logic [7:0] anodeSelect,
    output logic [6:0] segments,
    output logic       decimalPoint,
    output logic       buzzerOut,
    output logic       rangeError
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
    localparam int TW = (TONE_DIV > 1)    ? $clog2(TONE_DIV)    : 1;
    localparam int BW = (BEEP_DIV > 1)    ? $clog2(BEEP_DIV)    : 1;

    // ---------------- refresh timebase ----------------
    logic [RW-1:0] refresh_cnt;
    logic          refresh_wrap;

    assign refresh_wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));

    always_ff @(posedge clockSignal or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
        end else if (refresh_wrap) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // ---------------- input fields and range check ----------------
    logic [3:0][6:0] field_in;
    logic [3:0]      field_bad;

    always_comb begin
        field_in[F_HOURS]   = {2'b00, timeInHoursDisplay};
        field_in[F_MINUTES] = {1'b0, timeInMinutesDisplay};
        field_in[F_SECONDS] = {1'b0, timeInSeconds};
        field_in[F_CENTI]   = millisecondsDisplay;
        for (int f = 0; f < 4; f++) begin
            field_bad[f] = (field_in[f] > field_max(field_t'(f)));
        end
    end

    // ---------------- conversion FSM ----------------
    state_t          state;
    logic [3:0][6:0] snap;
    logic [3:0]      snap_bad;
    logic [2:0]      load_idx;
    field_t          cap_field;
    logic [3:0][7:0] work_bcd;
    logic [3:0][7:0] disp_bcd;
    logic [3:0]      disp_bad;
    logic            display_valid;

    logic            bcd_start;
    logic            bcd_busy;
    logic            bcd_done;
    logic [7:0]      bcd_out;

    // A new field loads in the same cycle the previous one reports done,
    // keeping each field at exactly eight cycles.
    assign bcd_start = (state == S_CONV) && !bcd_busy && !load_idx[2];

    bin2bcd_seq u_bin2bcd (
        .clk   (clockSignal),
        .rst   (reset),
        .start (bcd_start),
        .bin   (snap[load_idx[1:0]]),
        .busy  (bcd_busy),
        .done  (bcd_done),
        .bcd   (bcd_out)
    );

    always_ff @(posedge clockSignal or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            snap          <= '0;
            snap_bad      <= '0;
            load_idx      <= '0;
            cap_field     <= F_HOURS;
            work_bcd      <= '0;
            disp_bcd      <= '0;
            disp_bad      <= '0;
            display_valid <= 1'b0;
            rangeError    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (refresh_wrap) begin
                        snap     <= field_in;
                        snap_bad <= field_bad;
                        load_idx <= '0;
                        state    <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (bcd_start) begin
                        load_idx  <= load_idx + 3'd1;
                        cap_field <= field_t'(load_idx[1:0]);
                    end
                    if (bcd_done) begin
                        work_bcd[cap_field] <= bcd_out;
                        if (cap_field == F_CENTI) begin
                            state <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    disp_bcd      <= work_bcd;
                    disp_bad      <= snap_bad;
                    display_valid <= 1'b1;
                    rangeError    <= |snap_bad;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------- display scan ----------------
    logic [SW-1:0] scan_cnt;
    logic          scan_wrap;
    logic [2:0]    digit_idx;
    field_t        digit_field;
    logic [3:0]    digit_val;
    logic [6:0]    digit_seg;
    logic          digit_dp;

    // Digit 7 is hours tens, digit 0 is centiseconds ones: field = (7 - idx) / 2.
    always_comb begin
        scan_wrap   = (scan_cnt == SW'(SCAN_DIV - 1));
        digit_field = field_t'(~digit_idx[2:1]);
        digit_val   = digit_idx[0] ? disp_bcd[digit_field][7:4] : disp_bcd[digit_field][3:0];
        digit_seg   = disp_bad[digit_field] ? SEG_DASH : seg_encode(digit_val);
        digit_dp    = ~((digit_idx[0] == 1'b0) && (digit_idx != 3'd0));
    end

    always_ff @(posedge clockSignal or posedge reset) begin
        if (reset) begin
            scan_cnt     <= '0;
            digit_idx    <= '0;
            anodeSelect  <= 8'hFF;
            segments     <= SEG_BLANK;
            decimalPoint <= 1'b1;
        end else begin
            if (scan_wrap) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx - 3'd1;
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
            // The wrap cycle is blanked so the old pattern never shows on the new digit.
            if (!display_valid || scan_wrap) begin
                anodeSelect  <= 8'hFF;
                segments     <= SEG_BLANK;
                decimalPoint <= 1'b1;
            end else begin
                anodeSelect  <= ~(8'd1 << digit_idx);
                segments     <= digit_seg;
                decimalPoint <= digit_dp;
            end
        end
    end

    // ---------------- buzzer ----------------
    logic          ring_s1;
    logic          ring_s2;
    logic          ring_prev;
    logic [TW-1:0] tone_cnt;
    logic [BW-1:0] beep_cnt;
    logic          tone;
    logic          gate;
    logic          tone_wrap;
    logic          gate_wrap;
    logic          tone_next;
    logic          gate_next;

    always_comb begin
        tone_wrap = (tone_cnt == TW'(TONE_DIV - 1));
        gate_wrap = (beep_cnt == BW'(BEEP_DIV - 1));
        tone_next = tone ^ tone_wrap;
        gate_next = gate ^ gate_wrap;
    end

    always_ff @(posedge clockSignal or posedge reset) begin
        if (reset) begin
            ring_s1   <= 1'b0;
            ring_s2   <= 1'b0;
            ring_prev <= 1'b0;
            tone_cnt  <= '0;
            beep_cnt  <= '0;
            tone      <= 1'b0;
            gate      <= 1'b0;
            buzzerOut <= 1'b0;
        end else begin
            ring_s1   <= ringSound;
            ring_s2   <= ring_s1;
            ring_prev <= ring_s2;
            if (!ring_s2) begin
                tone_cnt  <= '0;
                beep_cnt  <= '0;
                tone      <= 1'b0;
                gate      <= 1'b0;
                buzzerOut <= 1'b0;
            end else if (!ring_prev) begin
                // Each new alarm starts audibly at the beginning of a beep.
                tone_cnt  <= '0;
                beep_cnt  <= '0;
                tone      <= 1'b1;
                gate      <= 1'b1;
                buzzerOut <= 1'b1;
            end else begin
                tone_cnt  <= tone_wrap ? '0 : tone_cnt + TW'(1);
                beep_cnt  <= gate_wrap ? '0 : beep_cnt + BW'(1);
                tone      <= tone_next;
                gate      <= gate_next;
                buzzerOut <= tone_next & gate_next;
            end
        end
    end

endmodule

// File: tb/tb_time_display_driver.sv
// Directed bench for time_display_driver with small dividers: display content,
// commit atomicity, range dashes, in-flight isolation, buzzer pattern and reset.
module tb_time_display_driver;

  localparam int REFRESH_DIV = 64;
  localparam int SCAN_DIV    = 4;
  localparam int TONE_DIV    = 3;
  localparam int BEEP_DIV    = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [6:0] centi;
  logic       ring;
  logic [7:0] anode;
  logic [6:0] seg;
  logic       dp;
  logic       buzz;
  logic       range_err;

  time_display_driver #(
    .REFRESH_DIV (REFRESH_DIV),
    .SCAN_DIV    (SCAN_DIV),
    .TONE_DIV    (TONE_DIV),
    .BEEP_DIV    (BEEP_DIV)
  ) dut (
    .clockSignal          (clk),
    .reset                (rst),
    .timeInHoursDisplay   (hours),
    .timeInMinutesDisplay (minutes),
    .timeInSeconds        (seconds),
    .millisecondsDisplay  (centi),
    .ringSound            (ring),
    .anodeSelect          (anode),
    .segments             (seg),
    .decimalPoint         (dp),
    .buzzerOut            (buzz),
    .rangeError           (range_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [6:0] seg_tab [10];
  logic [6:0] exp_seg [8];
  logic       exp_dp  [8];
  logic [6:0] old_seg [8];
  logic [6:0] frm_seg [8];
  logic       frm_dp  [8];
  logic [7:0] frm_seen;
  logic       frm_multi;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  function automatic int next_wrap();
    return ((cyc / REFRESH_DIV) + 1) * REFRESH_DIV;
  endfunction

  task automatic set_fields(input int h, input int m, input int s, input int c);
    hours   = 5'(h);
    minutes = 6'(m);
    seconds = 6'(s);
    centi   = 7'(c);
  endtask

  task automatic build_expect(input int h, input int m, input int s, input int c);
    int val;
    int max_val;
    for (int i = 0; i < 8; i++) begin
      case ((7 - i) / 2)
        0:       begin val = h; max_val = 23; end
        1:       begin val = m; max_val = 59; end
        2:       begin val = s; max_val = 59; end
        default: begin val = c; max_val = 99; end
      endcase
      if (val > max_val) exp_seg[i] = 7'h3F;
      else if (i % 2 == 1) exp_seg[i] = seg_tab[val / 10];
      else exp_seg[i] = seg_tab[val % 10];
      exp_dp[i] = !(i == 6 || i == 4 || i == 2);
    end
  endtask

  task automatic capture_frame();
    frm_seen  = '0;
    frm_multi = 1'b0;
    for (int t = 0; t < 16 * SCAN_DIV && frm_seen != 8'hFF; t++) begin
      tick();
      if (anode !== 8'hFF) begin
        if ($countones(~anode) != 1) frm_multi = 1'b1;
        for (int i = 0; i < 8; i++) begin
          if (anode[i] === 1'b0) begin
            frm_seen[i] = 1'b1;
            frm_seg[i]  = seg;
            frm_dp[i]   = dp;
          end
        end
      end
    end
  endtask

  task automatic run_to_display(output int w);
    w = next_wrap();
    wait_to(w + 36);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    ring = 1'b0;
    set_fields(13, 45, 7, 99);
    tick(); tick(); tick();
    total++; if (anode !== 8'hFF) begin bad++; $display("FAIL reset_anode: got %h want ff", anode); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %h want 7f", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp: got %b want 1", dp); end
    total++; if (buzz !== 1'b0) begin bad++; $display("FAIL reset_buzz: got %b want 0", buzz); end
    total++; if (range_err !== 1'b0) begin bad++; $display("FAIL reset_range: got %b want 0", range_err); end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_first_display();
    build_expect(13, 45, 7, 99);
    wait_to(97);
    total++; if (anode !== 8'hFF) begin bad++; $display("FAIL first_latency_early: got %h want ff", anode); end
    wait_to(99);
    total++; if (anode === 8'hFF) begin bad++; $display("FAIL first_latency_late: got %h want a digit enabled", anode); end
    capture_frame();
    total++; if (frm_multi !== 1'b0) begin bad++; $display("FAIL first_onehot: got multiple enables want one"); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (frm_seen[i] !== 1'b1 || frm_seg[i] !== exp_seg[i] || frm_dp[i] !== exp_dp[i]) begin
        bad++;
        $display("FAIL first_digit%0d: seen=%b seg=%h dp=%b want seg=%h dp=%b", i, frm_seen[i], frm_seg[i], frm_dp[i], exp_seg[i], exp_dp[i]);
      end
    end
    total++; if (range_err !== 1'b0) begin bad++; $display("FAIL first_range: got %b want 0", range_err); end
  endtask

  task automatic test_back_to_back();
    int w;
    int idx;
    logic [6:0] want;
    set_fields(23, 59, 59, 99);
    build_expect(23, 59, 59, 99);
    run_to_display(w);
    capture_frame();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (frm_seen[i] !== 1'b1 || frm_seg[i] !== exp_seg[i]) begin
        bad++;
        $display("FAIL max_digit%0d: seen=%b seg=%h want %h", i, frm_seen[i], frm_seg[i], exp_seg[i]);
      end
      old_seg[i] = exp_seg[i];
    end
    set_fields(0, 0, 0, 0);
    build_expect(0, 0, 0, 0);
    w = next_wrap();
    while (cyc < w + 34 + 40) begin
      tick();
      if (anode !== 8'hFF) begin
        idx = 0;
        for (int i = 7; i >= 0; i--) if (anode[i] === 1'b0) idx = i;
        want = (cyc >= w + 35) ? exp_seg[idx] : old_seg[idx];
        total++;
        if (seg !== want) begin
          bad++;
          $display("FAIL frame_switch cyc=%0d digit%0d: got %h want %h", cyc - w, idx, seg, want);
        end
      end
    end
    capture_frame();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (frm_seen[i] !== 1'b1 || frm_seg[i] !== exp_seg[i]) begin
        bad++;
        $display("FAIL zero_digit%0d: seen=%b seg=%h want %h", i, frm_seen[i], frm_seg[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_inflight();
    int w;
    set_fields(8, 30, 42, 17);
    build_expect(8, 30, 42, 17);
    w = next_wrap();
    wait_to(w);
    for (int t = 0; t < 34; t++) begin
      set_fields($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 99));
      tick();
    end
    set_fields(8, 30, 42, 17);
    wait_to(w + 36);
    capture_frame();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (frm_seen[i] !== 1'b1 || frm_seg[i] !== exp_seg[i]) begin
        bad++;
        $display("FAIL inflight_digit%0d: seen=%b seg=%h want %h", i, frm_seen[i], frm_seg[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_range();
    int w;
    set_fields(24, 60, 0, 100);
    build_expect(24, 60, 0, 100);
    run_to_display(w);
    capture_frame();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (frm_seen[i] !== 1'b1 || frm_seg[i] !== exp_seg[i] || frm_dp[i] !== exp_dp[i]) begin
        bad++;
        $display("FAIL range_digit%0d: seen=%b seg=%h dp=%b want seg=%h dp=%b", i, frm_seen[i], frm_seg[i], frm_dp[i], exp_seg[i], exp_dp[i]);
      end
    end
    total++; if (range_err !== 1'b1) begin bad++; $display("FAIL range_set: got %b want 1", range_err); end
    set_fields(1, 2, 3, 4);
    build_expect(1, 2, 3, 4);
    run_to_display(w);
    total++; if (range_err !== 1'b0) begin bad++; $display("FAIL range_clear: got %b want 0", range_err); end
    capture_frame();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (frm_seen[i] !== 1'b1 || frm_seg[i] !== exp_seg[i]) begin
        bad++;
        $display("FAIL range_clear_digit%0d: seen=%b seg=%h want %h", i, frm_seen[i], frm_seg[i], exp_seg[i]);
      end
    end
  endtask

  task automatic test_buzzer();
    logic want;
    ring = 1'b1;
    tick(); tick();
    total++; if (buzz !== 1'b0) begin bad++; $display("FAIL buzz_early: got %b want 0", buzz); end
    for (int k = 0; k < 97; k++) begin
      tick();
      want = (((k / TONE_DIV) % 2) == 0) && (((k / BEEP_DIV) % 2) == 0);
      total++;
      if (buzz !== want) begin bad++; $display("FAIL buzz_pattern k=%0d: got %b want %b", k, buzz, want); end
    end
    ring = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (buzz !== 1'b0) begin bad++; $display("FAIL buzz_stop k=%0d: got %b want 0", k, buzz); end
      tick();
    end
  endtask

  task automatic test_reset_mid_conv();
    int w;
    set_fields(24, 60, 0, 100);
    run_to_display(w);
    total++; if (range_err !== 1'b1) begin bad++; $display("FAIL midrst_pre_range: got %b want 1", range_err); end
    w = next_wrap();
    wait_to(w + 7);
    ring = 1'b1;
    set_fields(5, 6, 7, 8);
    wait_to(w + 11);
    total++; if (buzz !== 1'b1) begin bad++; $display("FAIL midrst_pre_buzz: got %b want 1", buzz); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (anode !== 8'hFF) begin bad++; $display("FAIL midrst_anode: got %h want ff", anode); end
    total++; if (seg !== 7'h7F) begin bad++; $display("FAIL midrst_seg: got %h want 7f", seg); end
    total++; if (dp !== 1'b1) begin bad++; $display("FAIL midrst_dp: got %b want 1", dp); end
    total++; if (buzz !== 1'b0) begin bad++; $display("FAIL midrst_buzz: got %b want 0", buzz); end
    total++; if (range_err !== 1'b0) begin bad++; $display("FAIL midrst_range: got %b want 0", range_err); end
    ring = 1'b0;
    tick(); tick();
    rst = 1'b0;
    cyc = 0;
    build_expect(5, 6, 7, 8);
    while (cyc < 98) begin
      tick();
      total++;
      if (anode !== 8'hFF) begin bad++; $display("FAIL midrst_blank cyc=%0d: got %h want ff", cyc, anode); end
    end
    wait_to(99);
    capture_frame();
    for (int i = 0; i < 8; i++) begin
      total++;
      if (frm_seen[i] !== 1'b1 || frm_seg[i] !== exp_seg[i]) begin
        bad++;
        $display("FAIL midrst_digit%0d: seen=%b seg=%h want %h", i, frm_seen[i], frm_seg[i], exp_seg[i]);
      end
    end
    total++; if (range_err !== 1'b0) begin bad++; $display("FAIL midrst_post_range: got %b want 0", range_err); end
  endtask

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
    test_reset();
    test_first_display();
    test_back_to_back();
    test_inflight();
    test_range();
    test_buzzer();
    test_reset_mid_conv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
